// File: rtl/des_pkg.sv
// des_pkg: DES S-box tables, box index type and stage FSM states.
package des_pkg;
    typedef logic [2:0] sbox_idx_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    // One 256-bit word per box: 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
endpackage

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: combinational lookup of one DES S-box selected by index.
module des_sbox_lut
    import des_pkg::*;
(
    input  sbox_idx_t   box_i,
    input  logic [5:0]  six_i,
    output logic [3:0]  res_o
);
    // Row is the outer bit pair, column the inner four bits.
    logic [5:0] entry;
    assign entry = {six_i[5], six_i[0], six_i[4:1]};
    assign res_o = SBOX_TAB[box_i][255 - 4*entry -: 4];
endmodule

// File: rtl/des_sbox_serial.sv
// des_sbox_serial: iterative DES S1..S8 substitution, SBOX_PER_CYCLE boxes per clock,
// valid/ready on both sides with back-to-back acceptance from DONE.
module des_sbox_serial
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:47] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] data_out
);
    localparam int N = SBOX_PER_CYCLE;
    localparam sbox_idx_t LAST = 3'(8 - N);

    if (!(N == 1 || N == 2 || N == 4 || N == 8)) begin : g_bad_param
        $error("SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e     state_q;
    logic [0:47] blk_q;
    logic [0:31] out_q;
    sbox_idx_t  idx_q;
    sbox_idx_t  idx_d;
    sbox_idx_t  box [N];
    logic [3:0] res [N];
    logic       accept;

    for (genvar k = 0; k < N; k++) begin : g_lut
        assign box[k] = idx_q + 3'(k);
        des_sbox_lut u_lut (
            .box_i (box[k]),
            .six_i (blk_q[6*box[k] +: 6]),
            .res_o (res[k])
        );
    end

    assign idx_d     = idx_q + 3'(N);
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = state_q == DONE;
    assign data_out  = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            blk_q   <= data_in;
            idx_q   <= '0;
            state_q <= BUSY;
        end else if (state_q == BUSY) begin
            for (int k = 0; k < N; k++) out_q[4*box[k] +: 4] <= res[k];
            idx_q <= idx_d;
            if (idx_q == LAST) state_q <= DONE;
        end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_des_sbox_serial.sv
// tb_des_sbox_serial: directed and randomized checks of des_sbox_serial for N=1,2,4,8
// against a table-driven DES S-box model.
module tb_des_sbox_serial;
    logic        clk;
    logic        rst_n;
    logic [0:47] din;
    logic        iv   [4];
    logic        ordy [4];
    logic        irdy [4];
    logic        ov   [4];
    logic [0:31] dout [4];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_serial #(.SBOX_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .data_in   (din),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .data_out  (dout[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index = box*4 + row; column c sits at nibble c counted from the left.
    localparam logic [63:0] TB_S [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };
    localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                  2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    function automatic logic [0:31] ref_s(input logic [0:47] d);
        logic [0:31] r;
        logic [0:5]  b;
        int row, col;
        for (int i = 0; i < 8; i++) begin
            b = d[6*i +: 6];
            row = int'({b[0], b[5]});
            col = int'(b[1:4]);
            r[4*i +: 4] = TB_S[4*i + row][63 - 4*col -: 4];
        end
        return r;
    endfunction

    function automatic logic [0:31] perm_p(input logic [0:31] x);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) r[i] = x[P_TAB[i] - 1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_tick(input int k, input logic [0:47] d);
        din = d;
        iv[k] = 1'b1;
        ordy[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
        din = {$urandom(), 16'($urandom())};
    endtask

    task automatic wait_done(input int k, input logic [0:47] d, input int lat,
                             input logic ordy_val, input string tag);
        int n = 0;
        ordy[k] = ordy_val;
        while (!ov[k] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_data"}, 64'(dout[k]), 64'(ref_s(d)));
    endtask

    task automatic run_random(input int k, input int nv);
        logic [0:47] exp_q [$];
        int sent = 0, got = 0, cyc = 0;
        while (got < nv && cyc < nv * 40) begin
            @(posedge clk);
            #1;
            iv[k] = (sent < nv) && ($urandom_range(3) != 0);
            din = {$urandom(), 16'($urandom())};
            ordy[k] = $urandom_range(1) == 1;
            @(negedge clk);
            cyc++;
            if (ov[k] && ordy[k]) begin
                chk("rand_outstanding", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) chk("rand_data", 64'(dout[k]), 64'(ref_s(exp_q.pop_front())));
                got++;
            end
            if (iv[k] && irdy[k]) begin
                exp_q.push_back(din);
                sent++;
            end
        end
        chk("rand_count", 64'(got), 64'(nv));
        chk("rand_leftover", 64'(exp_q.size()), 64'd0);
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:47] d1, d2;
        rst_n = 1'b0;
        din = '0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_in_ready", 64'(irdy[k]), 64'd1);
            chk("reset_out_valid", 64'(ov[k]), 64'd0);
            chk("reset_data_out", 64'(dout[k]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        accept_tick(0, 48'h0);
        wait_done(0, 48'h0, 8, 1'b1, "zero_n1");
        chk("zero_const", 64'(dout[0]), 64'hEFA72C4D);

        for (int k = 0; k < 4; k++) begin
            accept_tick(k, '1);
            wait_done(k, '1, 8 >> k, 1'b1, "ones");
            chk("ones_const", 64'(dout[k]), 64'hD9CE3DCB);
        end

        accept_tick(0, 48'h6117BA866527);
        wait_done(0, 48'h6117BA866527, 8, 1'b1, "fips");
        chk("fips_perm", 64'(perm_p(dout[0])), 64'h234AA9BB);
        tick();

        // Backpressure, then back-to-back acceptance out of the stalled result.
        d1 = {$urandom(), 16'($urandom())};
        d2 = {$urandom(), 16'($urandom())};
        accept_tick(0, d1);
        wait_done(0, d1, 8, 1'b0, "bp_first");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 64'(ov[0]), 64'd1);
            chk("bp_hold_data", 64'(dout[0]), 64'(ref_s(d1)));
            chk("bp_hold_in_ready", 64'(irdy[0]), 64'd0);
        end
        din = d2;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(irdy[0]), 64'd1);
        tick();
        iv[0] = 1'b0;
        din = '0;
        chk("b2b_busy_valid", 64'(ov[0]), 64'd0);
        chk("b2b_busy_in_ready", 64'(irdy[0]), 64'd0);
        wait_done(0, d2, 8, 1'b1, "b2b");
        tick();

        // Asynchronous reset in the middle of BUSY.
        accept_tick(0, d1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_in_ready", 64'(irdy[0]), 64'd1);
        chk("areset_out_valid", 64'(ov[0]), 64'd0);
        chk("areset_data_out", 64'(dout[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("areset_no_valid", 64'(ov[0]), 64'd0);
        accept_tick(0, d2);
        wait_done(0, d2, 8, 1'b1, "after_reset");
        tick();

        for (int k = 0; k < 4; k++) run_random(k, 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
